// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if -- bundle of the fetch/backend/icache/memory signals seen by
// the fetch-PC controller.
//
//   stall          backend stall, hold the current PC
//   pc_check       {enable, pc_new} next-PC proposal from fetch
//   redirect_valid backend mispredict/exception redirect
//   redirect_pc    redirect target
//   icache_hit     icache holds the line for the current pc
//   refill_req     refill request valid                (controller -> memory)
//   refill_ack     memory accepted the request
//   refill_done    line has been written into the icache
//   refill_addr    line-aligned miss address           (controller -> memory)
//   pc             current fetch PC                    (controller -> fetch)
//   fetch_valid    fetch group at pc is valid this cycle
//   miss_cnt       saturating icache-miss counter
//
// modport slave  : the fetch_ctrl block itself
// modport master : the surrounding environment driving/observing it
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;

    typedef struct packed {
        logic        enable;
        logic [31:0] pc_new;
    } pc_check_t;

    logic        stall;
    pc_check_t   pc_check;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        icache_hit;
    logic        refill_req;
    logic        refill_ack;
    logic        refill_done;
    logic [31:0] refill_addr;
    logic [31:0] pc;
    logic        fetch_valid;
    logic [31:0] miss_cnt;

    modport slave (
        input  stall, pc_check, redirect_valid, redirect_pc, icache_hit,
               refill_ack, refill_done,
        output refill_req, refill_addr, pc, fetch_valid, miss_cnt
    );

    modport master (
        output stall, pc_check, redirect_valid, redirect_pc, icache_hit,
               refill_ack, refill_done,
        input  refill_req, refill_addr, pc, fetch_valid, miss_cnt
    );

endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- fetch PC sequencer with icache miss/refill handling.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_ctrl_if.slave (stall, pc_check, redirect, icache_hit,
//          refill handshake, pc, fetch_valid, miss_cnt)
//
// Parameters:
//   RESET_PC    PC loaded on reset
//   LINE_BYTES  icache line size in bytes, power of two, >= 16
//
// A miss in RUN walks RUN -> REQ -> WAIT -> DRAIN -> RUN. A refill is never
// aborted; redirects seen during REQ/WAIT are parked in a pending register
// and applied in DRAIN.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter int          LINE_BYTES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.slave   bus
);

    localparam int          OFF_W     = $clog2(LINE_BYTES);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);

    generate
        if (LINE_BYTES < 16 || (LINE_BYTES & (LINE_BYTES - 1)) != 0) begin : g_bad_line
            $error("fetch_ctrl: LINE_BYTES must be a power of two and >= 16");
        end
    endgenerate

    typedef enum logic [1:0] {RUN, REQ, WAIT, DRAIN} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] miss_cnt_q;
    logic        refill_req_q;
    logic [31:0] refill_addr_q;
    logic        pend_vld_q;
    logic [31:0] pend_pc_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            miss_cnt_q    <= 32'd0;
            refill_req_q  <= 1'b0;
            refill_addr_q <= 32'd0;
            pend_vld_q    <= 1'b0;
            pend_pc_q     <= 32'd0;
        end else begin
            case (state_q)
                RUN: begin
                    // Redirect wins even over stall; a stalled miss is not
                    // yet counted, the lookup is retried once stall drops.
                    if (bus.redirect_valid) begin
                        pc_q <= bus.redirect_pc;
                    end else if (!bus.stall) begin
                        if (!bus.icache_hit) begin
                            state_q       <= REQ;
                            refill_req_q  <= 1'b1;
                            refill_addr_q <= pc_q & LINE_MASK;
                            miss_cnt_q    <= sat_inc(miss_cnt_q);
                        end else if (bus.pc_check.enable) begin
                            pc_q <= bus.pc_check.pc_new;
                        end
                    end
                end
                REQ: begin
                    if (bus.redirect_valid) begin
                        pend_vld_q <= 1'b1;
                        pend_pc_q  <= bus.redirect_pc;
                    end
                    if (bus.refill_ack) begin
                        refill_req_q <= 1'b0;
                        // ack and done together skip the WAIT state
                        state_q      <= bus.refill_done ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.redirect_valid) begin
                        pend_vld_q <= 1'b1;
                        pend_pc_q  <= bus.redirect_pc;
                    end
                    if (bus.refill_done) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A fresh redirect supersedes whatever was parked.
                    if (bus.redirect_valid) begin
                        pc_q <= bus.redirect_pc;
                    end else if (pend_vld_q) begin
                        pc_q <= pend_pc_q;
                    end
                    pend_vld_q <= 1'b0;
                    state_q    <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.miss_cnt    = miss_cnt_q;
    assign bus.refill_req  = refill_req_q;
    assign bus.refill_addr = refill_addr_q;
    // rst_n gate keeps fetch_valid low while reset is held.
    assign bus.fetch_valid = rst_n && (state_q == RUN) && bus.icache_hit &&
                             !bus.stall && !bus.redirect_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl.
// Each vector record carries the inputs for one cycle plus the expected
// fetch_valid (this cycle) and pc/refill_req/miss_cnt/refill_addr after the
// following rising edge; expectations are queued when driven and popped
// when the edge has produced the result.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl #(
        .RESET_PC  (32'hBFC0_0000),
        .LINE_BYTES(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        hit;
        logic        pce;
        logic [31:0] pnew;
        logic        ack;
        logic        done;
        logic        exp_fv;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_miss;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] stall, input logic [31:0] rv,
                                input logic [31:0] rpc, input logic [31:0] hit,
                                input logic [31:0] pce, input logic [31:0] pnew,
                                input logic [31:0] ack, input logic [31:0] done,
                                input logic [31:0] fv, input logic [31:0] pc,
                                input logic [31:0] req, input logic [31:0] miss,
                                input logic [31:0] addr);
        vec_t v;
        v.stall    = stall[0];
        v.rv       = rv[0];
        v.rpc      = rpc;
        v.hit      = hit[0];
        v.pce      = pce[0];
        v.pnew     = pnew;
        v.ack      = ack[0];
        v.done     = done[0];
        v.exp_fv   = fv[0];
        v.exp_pc   = pc;
        v.exp_req  = req[0];
        v.exp_miss = miss;
        v.exp_addr = addr;
        return v;
    endfunction

    // Called just after a rising edge: drive, check fetch_valid, clock once,
    // then compare the registered results.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        bus.stall           = v.stall;
        bus.redirect_valid  = v.rv;
        bus.redirect_pc     = v.rpc;
        bus.icache_hit      = v.hit;
        bus.pc_check.enable = v.pce;
        bus.pc_check.pc_new = v.pnew;
        bus.refill_ack      = v.ack;
        bus.refill_done     = v.done;
        #1;
        chk($sformatf("%s.fetch_valid", tag), {31'd0, bus.fetch_valid}, {31'd0, v.exp_fv});
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s.scoreboard actual=empty required=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s.pc", tag), bus.pc, e.exp_pc);
            chk($sformatf("%s.refill_req", tag), {31'd0, bus.refill_req}, {31'd0, e.exp_req});
            chk($sformatf("%s.miss_cnt", tag), bus.miss_cnt, e.exp_miss);
            if (e.exp_req)
                chk($sformatf("%s.refill_addr", tag), bus.refill_addr, e.exp_addr);
        end
    endtask

    initial begin : main
        logic [31:0] A;
        A = 32'hBFC0_0024;

        bus.stall           = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'd0;
        bus.icache_hit      = 1'b1;
        bus.pc_check.enable = 1'b0;
        bus.pc_check.pc_new = 32'd0;
        bus.refill_ack      = 1'b0;
        bus.refill_done     = 1'b0;

        //          stall rv rpc            hit pce pnew           ack done fv pc             req miss addr
        tbl[0]  = mk(0, 0, 0,              1, 1, 32'hBFC0_0010, 0, 0,  1, 32'hBFC0_0010, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,              1, 1, 32'hBFC0_0020, 0, 0,  1, 32'hBFC0_0020, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0,              1, 1, 32'hBFC0_0024, 0, 0,  1, A,             0, 0, 0);
        tbl[3]  = mk(1, 0, 0,              1, 1, 32'h1111_1110, 0, 0,  0, A,             0, 0, 0);
        tbl[4]  = mk(0, 0, 0,              1, 0, 0,             0, 0,  1, A,             0, 0, 0);
        tbl[5]  = mk(1, 1, 32'h8000_0180,  1, 0, 0,             0, 0,  0, 32'h8000_0180, 0, 0, 0);
        tbl[6]  = mk(0, 1, A,              1, 1, 32'h1234_5678, 0, 0,  0, A,             0, 0, 0);
        tbl[7]  = mk(1, 0, 0,              0, 0, 0,             0, 0,  0, A,             0, 0, 0);
        tbl[8]  = mk(0, 0, 0,              0, 0, 0,             0, 0,  0, A,             1, 1, 32'hBFC0_0020);
        tbl[9]  = mk(0, 0, 0,              1, 0, 0,             0, 0,  0, A,             1, 1, 32'hBFC0_0020);
        tbl[10] = mk(1, 0, 0,              1, 0, 0,             0, 0,  0, A,             1, 1, 32'hBFC0_0020);
        tbl[11] = mk(0, 0, 0,              1, 0, 0,             0, 0,  0, A,             1, 1, 32'hBFC0_0020);
        tbl[12] = mk(0, 0, 0,              1, 0, 0,             1, 0,  0, A,             0, 1, 0);
        tbl[13] = mk(0, 0, 0,              1, 0, 0,             0, 0,  0, A,             0, 1, 0);
        tbl[14] = mk(0, 0, 0,              1, 0, 0,             0, 1,  0, A,             0, 1, 0);
        tbl[15] = mk(0, 0, 0,              1, 0, 0,             0, 0,  0, A,             0, 1, 0);
        tbl[16] = mk(0, 0, 0,              1, 0, 0,             0, 0,  1, A,             0, 1, 0);

        // Reset state, with icache_hit high to show fetch_valid is held low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc", bus.pc, 32'hBFC0_0000);
        chk("rst.refill_req", {31'd0, bus.refill_req}, 32'd0);
        chk("rst.refill_addr", bus.refill_addr, 32'd0);
        chk("rst.fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
        chk("rst.miss_cnt", bus.miss_cnt, 32'd0);
        rst_n = 1'b1;

        // Sequential fetch, stall/redirect priority, first miss and refill.
        for (int i = 0; i < 17; i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // Two redirects while waiting: last one wins after DRAIN.
        apply(mk(0, 0, 0,             0, 0, 0, 0, 0, 0, A, 1, 2, 32'hBFC0_0020), "wr0");
        apply(mk(0, 0, 0,             1, 0, 0, 1, 0, 0, A, 0, 2, 0), "wr1");
        apply(mk(0, 1, 32'h8000_1000, 1, 0, 0, 0, 0, 0, A, 0, 2, 0), "wr2");
        apply(mk(0, 1, 32'h8000_2000, 1, 0, 0, 0, 0, 0, A, 0, 2, 0), "wr3");
        apply(mk(0, 0, 0,             1, 0, 0, 0, 1, 0, A, 0, 2, 0), "wr4");
        apply(mk(0, 0, 0,             1, 0, 0, 0, 0, 0, 32'h8000_2000, 0, 2, 0), "wr5");
        apply(mk(0, 0, 0,             1, 0, 0, 0, 0, 1, 32'h8000_2000, 0, 2, 0), "wr6");

        // ack+done together; DRAIN redirect beats pending; pending cleared.
        apply(mk(0, 0, 0,             0, 0, 0, 0, 0, 0, 32'h8000_2000, 1, 3, 32'h8000_2000), "ad0");
        apply(mk(0, 1, 32'h8000_3000, 1, 0, 0, 0, 0, 0, 32'h8000_2000, 1, 3, 32'h8000_2000), "ad1");
        apply(mk(0, 0, 0,             1, 0, 0, 1, 1, 0, 32'h8000_2000, 0, 3, 0), "ad2");
        apply(mk(0, 1, 32'h8000_4000, 1, 0, 0, 0, 0, 0, 32'h8000_4000, 0, 3, 0), "ad3");
        apply(mk(0, 0, 0,             1, 0, 0, 0, 0, 1, 32'h8000_4000, 0, 3, 0), "ad4");
        apply(mk(0, 0, 0,             0, 0, 0, 0, 0, 0, 32'h8000_4000, 1, 4, 32'h8000_4000), "ad5");
        apply(mk(0, 0, 0,             1, 0, 0, 1, 1, 0, 32'h8000_4000, 0, 4, 0), "ad6");
        apply(mk(0, 0, 0,             1, 0, 0, 0, 0, 0, 32'h8000_4000, 0, 4, 0), "ad7");

        // Reset in the middle of a refill request.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_4000, 1, 5, 32'h8000_4000), "mr0");
        bus.icache_hit = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mr.refill_req", {31'd0, bus.refill_req}, 32'd0);
        chk("mr.pc", bus.pc, 32'hBFC0_0000);
        chk("mr.miss_cnt", bus.miss_cnt, 32'd0);
        chk("mr.fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
        chk("mr.refill_addr", bus.refill_addr, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mk(0, 0, 0, 1, 0, 0, 0, 1, 1, 32'hBFC0_0000, 0, 0, 0), "mr1");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'hBFC0_0000, 0, 0, 0), "mr2");

        // Miss counter saturation.
        force dut.miss_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.miss_cnt_q;
        #1;
        chk("sat.preload", bus.miss_cnt, 32'hFFFF_FFFE);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 1, 32'hFFFF_FFFF, 32'hBFC0_0000), "sat0");
        apply(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 32'hBFC0_0000, 0, 32'hFFFF_FFFF, 0), "sat1");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0, 32'hFFFF_FFFF, 0), "sat2");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 1, 32'hFFFF_FFFF, 32'hBFC0_0000), "sat3");
        apply(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 32'hBFC0_0000, 0, 32'hFFFF_FFFF, 0), "sat4");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0, 32'hFFFF_FFFF, 0), "sat5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, the PC loaded on reset.
REQ-002 Parameter LINE_BYTES, default 16, the icache line size in bytes; it SHALL be a power of two and at least 16.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port stall, input, 1 bit: backend stall; hold the current PC.
REQ-006 Port pc_check, input, PC_CHECK (enable + 32-bit pc_new): next-PC proposal from fetch.
REQ-007 Port redirect_valid, input, 1 bit: backend mispredict/exception redirect.
REQ-008 Port redirect_pc, input, 32 bits: redirect target.
REQ-009 Port icache_hit, input, 1 bit: icache holds the line for the current pc.
REQ-010 Port refill_req, output, 1 bit: refill request valid.
REQ-011 Port refill_ack, input, 1 bit: memory accepts the request.
REQ-012 Port refill_done, input, 1 bit: line written into the icache.
REQ-013 Port refill_addr, output, 32 bits: line-aligned miss address.
REQ-014 Port pc, output, PC (32 bits): current fetch PC, driven to fetch.
REQ-015 Port fetch_valid, output, 1 bit: the fetch group at pc is valid for decode this cycle.
REQ-016 Port miss_cnt, output, 32 bits: saturating icache-miss counter.

Function
REQ-017 The FSM SHALL have exactly four states: RUN, REQ, WAIT and DRAIN; the encoding is free.
REQ-018 In RUN, fetch_valid SHALL be asserted iff icache_hit and not stall and not redirect_valid.
REQ-019 RUN next-PC priority SHALL be:
- redirect_valid: pc <= redirect_pc, even when stalled.
- stall: pc held.
- not icache_hit: pc held, go to REQ, miss_cnt += 1.
- pc_check.enable: pc <= pc_check.pc_new.
- otherwise: pc held.
REQ-020 In REQ, refill_req SHALL be 1 and refill_addr SHALL be pc with the low log2(LINE_BYTES) bits cleared.
REQ-021 refill_addr SHALL stay stable while refill_req is high, and the FSM SHALL move REQ -> WAIT on the cycle refill_ack is 1.
REQ-022 In WAIT, refill_req SHALL be 0 and fetch_valid SHALL be 0; on refill_done the FSM SHALL move WAIT -> DRAIN.
REQ-023 DRAIN SHALL last one cycle with fetch_valid 0, letting the icache lookup settle, then go -> RUN.
REQ-024 A refill SHALL NOT be aborted: redirect_valid in REQ or WAIT SHALL be latched into a pending register (valid + pc).
- A later redirect overwrites the earlier one.
- pc is unchanged until DRAIN.
REQ-025 In DRAIN with a pending redirect, pc SHALL be loaded from the pending pc and the pending flag cleared; redirect_valid arriving in DRAIN itself SHALL take priority over the pending value.
REQ-026 refill_ack and refill_done in the same cycle in REQ SHALL move the FSM directly to DRAIN.
REQ-027 miss_cnt SHALL saturate at 32'hFFFF_FFFF and not wrap.
REQ-028 pc_check.pc_new SHALL be used verbatim, with no alignment or arithmetic applied; only refill_addr is masked.
REQ-029 The stall input SHALL be ignored in REQ, WAIT and DRAIN, other than holding pc.

Reset
REQ-030 When rst_n = 0, the block SHALL asynchronously reset to:
- state RUN, pc = RESET_PC, miss_cnt = 0, pending flag = 0;
- refill_req = 0, refill_addr = 0, fetch_valid = 0.
REQ-031 Reset asserted mid-refill SHALL drop refill_req immediately; a refill_done arriving after reset release SHALL be ignored while in RUN.
REQ-032 The first cycle after reset release SHALL be in RUN, with fetch_valid following REQ-018.

Verification
REQ-033 Reset release; icache_hit = 1; pc_check.enable = 1 with pc_new = pc+16 each cycle -> pc steps BFC00000, BFC00010, BFC00020; fetch_valid = 1 every cycle.
REQ-034 pc = BFC00024, icache_hit = 0 -> next cycle REQ, refill_addr = BFC00020, miss_cnt = 1; ack after 3 cycles -> WAIT; refill_done -> DRAIN, then RUN with pc = BFC00024.
REQ-035 In WAIT, redirect_valid pulses with 80001000 and then 80002000 -> after refill_done and DRAIN, pc = 80002000; no refill is aborted.
REQ-036 stall = 1 with redirect_valid = 1 and redirect_pc = 80000180 in RUN -> next pc = 80000180; fetch_valid = 0 that cycle.
REQ-037 rst_n low during REQ -> refill_req = 0 combinationally; pc = BFC00000 after release; a stray refill_done is ignored.
REQ-038 miss_cnt preloaded to FFFFFFFE via force, then two misses -> miss_cnt = FFFFFFFF and stays there.
